log_motion_ctrl: RTL and testbench

Generates the horizontal positions and lengths of the two logs in each of the six river lanes, which feed the log renderer. On each frame tick, a small FSM walks the lanes serially, one lane per cycle. It advances per-lane frame dividers and steps logs by one pixel left or right, with wrap-around across the 448-px playfield. It also emits per-lane step pulses so the frog-riding logic can carry the frog with its log.

---
 rtl/frogger_pkg.sv | 21 ++
 rtl/log_lane_stepper.sv | 18 +
 rtl/log_motion_ctrl.sv | 131 +++++++++++++
 tb/tb_log_motion_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/frogger_pkg.sv
// Shared playfield constants and types for the log motion block.
package frogger_pkg;
  localparam int X_LEFT      = 96;
  localparam int X_RIGHT     = 544;
  localparam int BLOCKSIZE   = 32;
  localparam int LOG_SPACING = 224;
  localparam int NUM_LANES   = 6;
  localparam int XW          = 10;

  typedef logic [XW-1:0] xpos_t;
  typedef logic [2:0]    lane_t;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_e;

  // Second log sits half a playfield behind the first, wrapped into range.
  function automatic xpos_t log1_init(input xpos_t x0);
    logic [XW:0] s;
    s = {1'b0, x0} + 11'(LOG_SPACING);
    if (s > 11'(X_RIGHT - 1)) s = s - 11'(X_RIGHT - X_LEFT);
    return s[XW-1:0];
  endfunction
endpackage

// File: rtl/log_lane_stepper.sv
// One-pixel step of a log edge with wrap-around across the playfield.
module log_lane_stepper
  import frogger_pkg::*;
(
  input  logic [XW-1:0] x_i,
  input  logic [XW-1:0] len_i,
  input  logic          dir_i,
  output logic [XW-1:0] x_o
);
  xpos_t x_lo, x_hi;
  assign x_lo = xpos_t'(X_LEFT) - len_i;
  assign x_hi = xpos_t'(X_RIGHT - 1);

  always_comb begin
    if (dir_i) x_o = (x_i == x_hi) ? x_lo : x_i + 1'b1;
    else       x_o = (x_i == x_lo) ? x_hi : x_i - 1'b1;
  end
endmodule

// File: rtl/log_motion_ctrl.sv
// Walks the six river lanes once per frame tick, stepping log positions
// when each lane's frame divider expires.
module log_motion_ctrl
  import frogger_pkg::*;
#(
  parameter logic [5:0]  LANE_DIR     = 6'b010101,
  parameter logic [23:0] LANE_PERIOD  = 24'h234567,
  parameter logic [11:0] LANE_LEN_BLK = 12'b10_11_10_11_10_11,
  parameter logic [59:0] LANE_INIT_X  = {10'd400, 10'd300, 10'd200, 10'd100, 10'd32, 10'd543}
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          frame_tick,
  input  logic          enable,
  input  logic          restart,
  input  logic [1:0]    level,
  output logic [XW-1:0] lane0_log0_x, lane0_log1_x,
  output logic [XW-1:0] lane1_log0_x, lane1_log1_x,
  output logic [XW-1:0] lane2_log0_x, lane2_log1_x,
  output logic [XW-1:0] lane3_log0_x, lane3_log1_x,
  output logic [XW-1:0] lane4_log0_x, lane4_log1_x,
  output logic [XW-1:0] lane5_log0_x, lane5_log1_x,
  output logic [XW-1:0] lane0_loglength, lane1_loglength, lane2_loglength,
  output logic [XW-1:0] lane3_loglength, lane4_loglength, lane5_loglength,
  output logic [5:0]    lane_step,
  output logic [5:0]    lane_dir,
  output logic          busy,
  output logic          update_done
);
  logic [NUM_LANES-1:0][XW-1:0] init_x0, init_x1, len_all;
  logic [NUM_LANES-1:0][3:0]    per_all;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign init_x0[k] = LANE_INIT_X[XW*k +: XW];
    assign init_x1[k] = log1_init(LANE_INIT_X[XW*k +: XW]);
    assign len_all[k] = xpos_t'(LANE_LEN_BLK[2*k +: 2]) * xpos_t'(BLOCKSIZE);
    assign per_all[k] = LANE_PERIOD[4*k +: 4];
  end

  state_e                       state_q, state_d;
  lane_t                        idx_q, idx_d;
  logic [NUM_LANES-1:0][3:0]    cnt_q, cnt_d;
  logic [NUM_LANES-1:0][XW-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [NUM_LANES-1:0]         step_q, step_d;
  logic                         busy_q, busy_d, done_q, done_d;

  // Single shared datapath, muxed by the lane currently being processed.
  xpos_t      x0_sel, x1_sel, len_sel, x0_nxt, x1_nxt;
  logic       dir_sel;
  logic [3:0] per_sel, cnt_sel, cnt_nxt, eff;

  always_comb begin
    x0_sel = '0; x1_sel = '0; len_sel = '0; dir_sel = 1'b0; per_sel = '0; cnt_sel = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (idx_q == lane_t'(k)) begin
        x0_sel  = x0_q[k];
        x1_sel  = x1_q[k];
        len_sel = len_all[k];
        dir_sel = LANE_DIR[k];
        per_sel = per_all[k];
        cnt_sel = cnt_q[k];
      end
    end
  end

  always_comb begin
    eff = per_sel >> level;
    if (eff == 4'd0) eff = 4'd1;
  end
  assign cnt_nxt = cnt_sel + 4'd1;

  log_lane_stepper u_step0 (.x_i(x0_sel), .len_i(len_sel), .dir_i(dir_sel), .x_o(x0_nxt));
  log_lane_stepper u_step1 (.x_i(x1_sel), .len_i(len_sel), .dir_i(dir_sel), .x_o(x1_nxt));

  always_comb begin
    state_d = state_q; idx_d = idx_q; cnt_d = cnt_q;
    x0_d = x0_q; x1_d = x1_q; step_d = '0; busy_d = 1'b0; done_d = 1'b0;
    if (restart) begin
      state_d = IDLE; idx_d = '0; cnt_d = '0; x0_d = init_x0; x1_d = init_x1;
    end else begin
      case (state_q)
        IDLE: if (frame_tick && enable) begin
          state_d = UPDATE; idx_d = '0; busy_d = 1'b1;
        end
        UPDATE: begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (idx_q == lane_t'(k)) begin
              if (cnt_nxt >= eff) begin
                cnt_d[k] = '0; x0_d[k] = x0_nxt; x1_d[k] = x1_nxt; step_d[k] = 1'b1;
              end else begin
                cnt_d[k] = cnt_nxt;
              end
            end
          end
          if (idx_q == lane_t'(NUM_LANES - 1)) begin
            state_d = DONE; done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1; busy_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE; idx_q <= '0; cnt_q <= '0;
      x0_q <= init_x0; x1_q <= init_x1;
      step_q <= '0; busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; cnt_q <= cnt_d;
      x0_q <= x0_d; x1_q <= x1_d;
      step_q <= step_d; busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign lane0_log0_x = x0_q[0]; assign lane0_log1_x = x1_q[0];
  assign lane1_log0_x = x0_q[1]; assign lane1_log1_x = x1_q[1];
  assign lane2_log0_x = x0_q[2]; assign lane2_log1_x = x1_q[2];
  assign lane3_log0_x = x0_q[3]; assign lane3_log1_x = x1_q[3];
  assign lane4_log0_x = x0_q[4]; assign lane4_log1_x = x1_q[4];
  assign lane5_log0_x = x0_q[5]; assign lane5_log1_x = x1_q[5];
  assign lane0_loglength = len_all[0]; assign lane1_loglength = len_all[1];
  assign lane2_loglength = len_all[2]; assign lane3_loglength = len_all[3];
  assign lane4_loglength = len_all[4]; assign lane5_loglength = len_all[5];
  assign lane_step   = step_q;
  assign lane_dir    = LANE_DIR;
  assign busy        = busy_q;
  assign update_done = done_q;
endmodule

// File: tb/tb_log_motion_ctrl.sv
// Directed frame-by-frame bench for log_motion_ctrl with default parameters.
module tb_log_motion_ctrl;
  logic clk, reset_n, frame_tick, enable, restart;
  logic [1:0] level;
  logic [5:0][9:0] x0w, x1w, lenw;
  logic [5:0] lane_step, lane_dir;
  logic busy, update_done;

  int tests = 0;
  int fails = 0;

  localparam int INIT0 [6] = '{543, 32, 100, 200, 300, 400};
  localparam int INIT1 [6] = '{319, 256, 324, 424, 524, 176};
  localparam int LENS  [6] = '{96, 64, 96, 64, 96, 64};

  log_motion_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .enable(enable),
    .restart(restart), .level(level),
    .lane0_log0_x(x0w[0]), .lane0_log1_x(x1w[0]),
    .lane1_log0_x(x0w[1]), .lane1_log1_x(x1w[1]),
    .lane2_log0_x(x0w[2]), .lane2_log1_x(x1w[2]),
    .lane3_log0_x(x0w[3]), .lane3_log1_x(x1w[3]),
    .lane4_log0_x(x0w[4]), .lane4_log1_x(x1w[4]),
    .lane5_log0_x(x0w[5]), .lane5_log1_x(x1w[5]),
    .lane0_loglength(lenw[0]), .lane1_loglength(lenw[1]), .lane2_loglength(lenw[2]),
    .lane3_loglength(lenw[3]), .lane4_loglength(lenw[4]), .lane5_loglength(lenw[5]),
    .lane_step(lane_step), .lane_dir(lane_dir), .busy(busy), .update_done(update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit [1:0] lvl;
    bit       dup;   // inject extra ticks while busy / in DONE
    bit [5:0] mask;  // lanes expected to step this frame
    int       x0 [6];
    int       x1a;   // lane0 log1
    int       x1b;   // lane1 log1
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(bit en, bit [1:0] lvl, bit dup, bit [5:0] mask,
                              int a0, int a1, int a2, int a3, int a4, int a5, int b0, int b1);
    vec_t v;
    v.en = en; v.lvl = lvl; v.dup = dup; v.mask = mask;
    v.x0[0] = a0; v.x0[1] = a1; v.x0[2] = a2; v.x0[3] = a3; v.x0[4] = a4; v.x0[5] = a5;
    v.x1a = b0; v.x1b = b1;
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Cycle T is the one with frame_tick high; checks run at negedge of T+1..T+8.
  task automatic run_frame(input vec_t v, input int id);
    int ex;
    @(negedge clk);
    level = v.lvl; enable = v.en; frame_tick = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      frame_tick = v.dup && (n == 3 || n == 7);
      ex = 0;
      if (v.en) begin
        if (n <= 6) ex |= 'h80;
        if (n == 7) ex |= 'h40;
        if (n >= 2 && n <= 7 && v.mask[n-2]) ex |= (1 << (n - 2));
      end
      chk($sformatf("frame%0d ctl T+%0d", id, n), int'({busy, update_done, lane_step}), ex);
    end
    for (int k = 0; k < 6; k++)
      chk($sformatf("frame%0d lane%0d log0_x", id, k), int'(x0w[k]), v.x0[k]);
    chk($sformatf("frame%0d lane0 log1_x", id), int'(x1w[0]), v.x1a);
    chk($sformatf("frame%0d lane1 log1_x", id), int'(x1w[1]), v.x1b);
  endtask

  initial begin
    vec_t dis;
    reset_n = 1'b0; frame_tick = 1'b0; enable = 1'b0; restart = 1'b0; level = 2'd0;

    tbl[0]  = mk(1, 0, 0, 6'b000000, 543,  32, 100, 200, 300, 400, 319, 256);
    tbl[1]  = mk(1, 0, 0, 6'b100000, 543,  32, 100, 200, 300, 399, 319, 256);
    tbl[2]  = mk(1, 0, 0, 6'b010000, 543,  32, 100, 200, 301, 399, 319, 256);
    tbl[3]  = mk(1, 0, 0, 6'b101000, 543,  32, 100, 199, 301, 398, 319, 256);
    tbl[4]  = mk(1, 0, 0, 6'b000100, 543,  32, 101, 199, 301, 398, 319, 256);
    tbl[5]  = mk(1, 0, 0, 6'b110010, 543, 543, 101, 199, 302, 397, 319, 255);
    tbl[6]  = mk(1, 0, 0, 6'b000001,   0, 543, 101, 199, 302, 397, 320, 255);
    tbl[7]  = mk(1, 3, 0, 6'b111111,   1, 542, 102, 198, 303, 396, 321, 254);
    tbl[8]  = mk(1, 3, 0, 6'b111111,   2, 541, 103, 197, 304, 395, 322, 253);
    tbl[9]  = mk(1, 1, 0, 6'b110000,   2, 541, 103, 197, 305, 394, 322, 253);
    tbl[10] = mk(1, 1, 0, 6'b111100,   2, 541, 104, 196, 306, 393, 322, 253);
    tbl[11] = mk(1, 1, 0, 6'b110011,   3, 540, 104, 196, 307, 392, 323, 252);
    tbl[12] = mk(1, 1, 1, 6'b111100,   3, 540, 105, 195, 308, 391, 323, 252);
    tbl[13] = mk(1, 1, 0, 6'b110000,   3, 540, 105, 195, 309, 390, 323, 252);
    tbl[14] = mk(1, 1, 0, 6'b111111,   4, 539, 106, 194, 310, 389, 324, 251);
    tbl[15] = mk(1, 0, 0, 6'b000000,   4, 539, 106, 194, 310, 389, 324, 251);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset ctl", int'({busy, update_done, lane_step}), 0);
    chk("reset lane_dir", int'(lane_dir), 'b010101);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("reset lane%0d log0_x", k), int'(x0w[k]), INIT0[k]);
      chk($sformatf("reset lane%0d log1_x", k), int'(x1w[k]), INIT1[k]);
      chk($sformatf("lane%0d loglength", k), int'(lenw[k]), LENS[k]);
    end

    for (int i = 0; i < 16; i++) begin
      if (i == 13) begin
        // Disabled ticks: no motion, dividers frozen (checked by the next frames).
        dis = tbl[12]; dis.en = 0; dis.dup = 0; dis.mask = '0;
        for (int d = 0; d < 10; d++) run_frame(dis, 200 + d);
      end
      run_frame(tbl[i], i);
    end

    // Restart mid-update at T+3: lanes 0/1 already stepped, lane 2 in flight.
    @(negedge clk);
    level = 2'd3; enable = 1'b1; frame_tick = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      int ex;
      @(negedge clk);
      frame_tick = 1'b0;
      restart = (n == 3);
      ex = (n <= 3) ? 'h80 : 0;
      if (n == 2) ex |= 'h01;
      if (n == 3) ex |= 'h02;
      chk($sformatf("restart ctl T+%0d", n), int'({busy, update_done, lane_step}), ex);
      if (n == 2) chk("restart pre lane0 log0_x", int'(x0w[0]), 5);
      if (n == 4 || n == 8)
        for (int k = 0; k < 6; k++) begin
          chk($sformatf("restart T+%0d lane%0d log0_x", n, k), int'(x0w[k]), INIT0[k]);
          chk($sformatf("restart T+%0d lane%0d log1_x", n, k), int'(x1w[k]), INIT1[k]);
        end
    end
    restart = 1'b0;
    // Dividers must be cleared too: the first two frames replay from reset.
    run_frame(tbl[0], 100);
    run_frame(tbl[1], 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
